rcv_drain_ctrl: RTL and testbench

- Sequencing controller between rcv_block and the APB serial register interface.
- Samples rcv_block's data_ready, error_flag and overrun_error.
- Moves each good byte into a small internal FIFO and acknowledges rcv_block with a one-cycle data_read pulse.
- Keeps sticky error status and raises an interrupt for the bus side.

---
 rtl/rcv_drain_ctrl.sv | 157 +++++++++++++++
 tb/tb_rcv_drain_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcv_drain_ctrl.sv
// Drain controller between rcv_block and the bus-side register interface:
// acknowledges received bytes, buffers good ones in a small FIFO, tracks sticky status.
module rcv_drain_ctrl #(
  parameter int DEPTH        = 4,
  parameter int CNT_W        = $clog2(DEPTH) + 1,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             data_ready,
  input  logic             error_flag,
  input  logic             overrun_error,
  output logic             data_read,
  input  logic             pop,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count,
  input  logic             irq_en,
  input  logic [CNT_W-1:0] irq_thresh,
  input  logic             clr_status,
  output logic             stat_framing,
  output logic             stat_overrun,
  output logic             stat_drop,
  output logic             irq
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_WAIT_CLR = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_rd_data;

  logic             r_stat_framing;
  logic             r_stat_overrun;
  logic             r_stat_drop;
  logic             r_irq;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic             w_pop_en;
  logic             w_set_framing;
  logic             w_set_drop;
  logic             w_thresh_hit;
  logic             w_irq_nxt;

  // Full/empty come from the registered count, so a same-cycle pop never frees a slot early.
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_pop_en = pop & ~w_empty;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_en       = 1'b0;
    w_set_framing = 1'b0;
    w_set_drop    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (data_ready) begin
          if (error_flag) begin
            w_set_framing = 1'b1;
            w_state_nxt   = S_ACK;
          end else if (!w_full) begin
            w_wr_en     = 1'b1;
            w_state_nxt = S_ACK;
          end else if (DROP_ON_FULL) begin
            w_set_drop  = 1'b1;
            w_state_nxt = S_ACK;
          end
        end
      end
      S_ACK:      w_state_nxt = S_WAIT_CLR;
      S_WAIT_CLR: if (!data_ready) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_rd_ptr_nxt = w_pop_en ? (r_rd_ptr + 1'b1) : r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_ptr_nxt;
      unique case ({w_wr_en, w_pop_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage array has no reset; entries are only observed after being written.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= rx_data;
  end

  // Registered head: bypass the incoming byte when it lands exactly at the next head slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_rd_data <= 8'h00;
    else if (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) r_rd_data <= rx_data;
    else                                       r_rd_data <= r_mem[w_rd_ptr_nxt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_framing <= 1'b0;
      r_stat_overrun <= 1'b0;
      r_stat_drop    <= 1'b0;
    end else begin
      r_stat_framing <= w_set_framing | (r_stat_framing & ~clr_status);
      r_stat_overrun <= overrun_error | (r_stat_overrun & ~clr_status);
      r_stat_drop    <= w_set_drop    | (r_stat_drop    & ~clr_status);
    end
  end

  assign w_thresh_hit = (irq_thresh != '0) && (r_count >= irq_thresh);
  assign w_irq_nxt    = irq_en & (w_thresh_hit | r_stat_framing | r_stat_overrun | r_stat_drop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= w_irq_nxt;
  end

  assign data_read    = (r_state == S_ACK);
  assign rd_data      = r_rd_data;
  assign rd_valid     = ~w_empty;
  assign count        = r_count;
  assign stat_framing = r_stat_framing;
  assign stat_overrun = r_stat_overrun;
  assign stat_drop    = r_stat_drop;
  assign irq          = r_irq;

endmodule

// File: tb/tb_rcv_drain_ctrl.sv
// Bench for rcv_drain_ctrl: stall-mode and drop-mode instances share stimulus and are
// compared every cycle against a queue-based behavioural model.
module tb_rcv_drain_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rx_data;
  logic             data_ready;
  logic             error_flag;
  logic             overrun_error;
  logic             pop;
  logic             irq_en;
  logic [CNT_W-1:0] irq_thresh;
  logic             clr_status;

  logic [1:0]            data_read_o;
  logic [1:0][7:0]       rd_data_o;
  logic [1:0]            rd_valid_o;
  logic [1:0][CNT_W-1:0] count_o;
  logic [1:0]            stat_framing_o;
  logic [1:0]            stat_overrun_o;
  logic [1:0]            stat_drop_o;
  logic [1:0]            irq_o;

  always #5 clk = ~clk;

  rcv_drain_ctrl #(.DEPTH(DEPTH), .DROP_ON_FULL(1'b0)) u_stall (
    .clk(clk), .rst(rst), .rx_data(rx_data), .data_ready(data_ready),
    .error_flag(error_flag), .overrun_error(overrun_error), .data_read(data_read_o[0]),
    .pop(pop), .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]), .count(count_o[0]),
    .irq_en(irq_en), .irq_thresh(irq_thresh), .clr_status(clr_status),
    .stat_framing(stat_framing_o[0]), .stat_overrun(stat_overrun_o[0]),
    .stat_drop(stat_drop_o[0]), .irq(irq_o[0])
  );

  rcv_drain_ctrl #(.DEPTH(DEPTH), .DROP_ON_FULL(1'b1)) u_drop (
    .clk(clk), .rst(rst), .rx_data(rx_data), .data_ready(data_ready),
    .error_flag(error_flag), .overrun_error(overrun_error), .data_read(data_read_o[1]),
    .pop(pop), .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]), .count(count_o[1]),
    .irq_en(irq_en), .irq_thresh(irq_thresh), .clr_status(clr_status),
    .stat_framing(stat_framing_o[1]), .stat_overrun(stat_overrun_o[1]),
    .stat_drop(stat_drop_o[1]), .irq(irq_o[1])
  );

  int errors = 0;
  int checks = 0;

  // Model per mode: index 0 = stall, 1 = drop.
  logic [7:0] m_q [2][$];
  bit m_ack  [2];
  bit m_busy [2];
  bit m_fr   [2];
  bit m_ov   [2];
  bit m_dr   [2];
  bit m_irq  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_q[m].delete();
      m_ack[m]  = 1'b0;
      m_busy[m] = 1'b0;
      m_fr[m]   = 1'b0;
      m_ov[m]   = 1'b0;
      m_dr[m]   = 1'b0;
      m_irq[m]  = 1'b0;
    end
  endtask

  // One clock edge of the rules: a byte is taken only when no handshake is in
  // progress; the handshake ends once the acknowledge was shown and data_ready fell.
  task automatic model_edge();
    int n;
    bit take_fr, take_dr, ack_next;
    logic [7:0] dummy;
    if (rst) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      n        = m_q[m].size();
      take_fr  = 1'b0;
      take_dr  = 1'b0;
      ack_next = 1'b0;
      m_irq[m] = irq_en && (((irq_thresh != '0) && (n >= int'(irq_thresh))) ||
                            m_fr[m] || m_ov[m] || m_dr[m]);
      if (pop && n > 0) dummy = m_q[m].pop_front();
      if (!m_ack[m] && !m_busy[m] && data_ready) begin
        if (error_flag) begin
          take_fr  = 1'b1;
          ack_next = 1'b1;
        end else if (n < DEPTH) begin
          m_q[m].push_back(rx_data);
          ack_next = 1'b1;
        end else if (m == 1) begin
          take_dr  = 1'b1;
          ack_next = 1'b1;
        end
      end
      if (m_ack[m])                     m_busy[m] = 1'b1;
      else if (m_busy[m] && !data_ready) m_busy[m] = 1'b0;
      m_ack[m] = ack_next;
      m_fr[m]  = take_fr       || (m_fr[m] && !clr_status);
      m_ov[m]  = overrun_error || (m_ov[m] && !clr_status);
      m_dr[m]  = take_dr       || (m_dr[m] && !clr_status);
    end
  endtask

  task automatic compare_all(input string tag);
    string nm;
    for (int m = 0; m < 2; m++) begin
      nm = (m == 0) ? {tag, "/stall"} : {tag, "/drop"};
      check({nm, " data_read"},    data_read_o[m],    m_ack[m]);
      check({nm, " count"},        count_o[m],        m_q[m].size());
      check({nm, " rd_valid"},     rd_valid_o[m],     m_q[m].size() != 0);
      if (m_q[m].size() != 0)
        check({nm, " rd_data"},    rd_data_o[m],      m_q[m][0]);
      check({nm, " stat_framing"}, stat_framing_o[m], m_fr[m]);
      check({nm, " stat_overrun"}, stat_overrun_o[m], m_ov[m]);
      check({nm, " stat_drop"},    stat_drop_o[m],    m_dr[m]);
      check({nm, " irq"},          irq_o[m],          m_irq[m]);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic send(input logic [7:0] b, input logic err, input string tag);
    data_ready = 1'b1;
    rx_data    = b;
    error_flag = err;
    step(tag);
    step(tag);
    data_ready = 1'b0;
    error_flag = 1'b0;
    step(tag);
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; data_ready = 1'b0; error_flag = 1'b0;
    overrun_error = 1'b0; pop = 1'b0; irq_en = 1'b0; irq_thresh = '0; clr_status = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    check("reset rd_data", rd_data_o[0], 8'h00);
    step("reset_edge");
    rst = 1'b0;
    step("idle");

    // Single good byte
    data_ready = 1'b1; rx_data = 8'hD5;
    step("single_cap");
    check("single count",     count_o[0],     1);
    check("single rd_data",   rd_data_o[0],   8'hD5);
    check("single data_read", data_read_o[0], 1);
    step("single_wait");
    check("single ack one cycle", data_read_o[0], 0);
    step("single_no_double");
    check("single no double capture", count_o[0], 1);
    data_ready = 1'b0;
    step("single_idle");
    pop = 1'b1;
    step("single_pop");
    pop = 1'b0;
    check("single pop count",    count_o[0],    0);
    check("single pop rd_valid", rd_valid_o[0], 0);

    // Framing error and sticky clear
    data_ready = 1'b1; rx_data = 8'h3C; error_flag = 1'b1;
    step("framing");
    check("framing count",     count_o[0],        0);
    check("framing data_read", data_read_o[0],    1);
    check("framing stat",      stat_framing_o[0], 1);
    step("framing_wait");
    data_ready = 1'b0; error_flag = 1'b0;
    step("framing_idle");
    clr_status = 1'b1;
    step("framing_clr");
    check("framing cleared", stat_framing_o[0], 0);
    data_ready = 1'b1; error_flag = 1'b1;
    step("framing_set_wins");
    check("framing set beats clear", stat_framing_o[0], 1);
    clr_status = 1'b0;
    step("framing_wait2");
    data_ready = 1'b0; error_flag = 1'b0;
    step("framing_idle2");
    clr_status = 1'b1;
    step("framing_clr2");
    clr_status = 1'b0;

    // Fill to full, fifth byte stalls (stall) or is dropped (drop)
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, "fill");
    data_ready = 1'b1; rx_data = 8'h05;
    step("full_fifth");
    check("full stall no ack",   data_read_o[0], 0);
    check("full stall count",    count_o[0],     4);
    check("full drop ack",       data_read_o[1], 1);
    check("full drop stat",      stat_drop_o[1], 1);
    check("full drop count",     count_o[1],     4);
    step("full_hold");
    check("full stall still no ack", data_read_o[0], 0);
    check("full drop head",          rd_data_o[1],   8'h01);
    pop = 1'b1;
    step("full_pop");
    pop = 1'b0;
    check("full pop refused write", count_o[0], 3);
    step("full_retry");
    check("full retry ack",   data_read_o[0], 1);
    check("full retry count", count_o[0],     4);
    data_ready = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      check("full order", rd_data_o[0], 8'(k));
      pop = 1'b1;
      step("full_drain");
    end
    pop = 1'b0;
    clr_status = 1'b1;
    step("full_clr");
    clr_status = 1'b0;

    // Interrupt threshold and overrun
    irq_en = 1'b1; irq_thresh = 3'd2;
    step("irq_idle");
    send(8'h11, 1'b0, "irq_b1");
    check("irq below thresh", irq_o[0], 0);
    data_ready = 1'b1; rx_data = 8'h22;
    step("irq_b2");
    check("irq lags count", irq_o[0], 0);
    step("irq_b2_wait");
    check("irq at thresh", irq_o[0], 1);
    data_ready = 1'b0;
    pop = 1'b1;
    step("irq_pop");
    step("irq_pop");
    pop = 1'b0;
    overrun_error = 1'b1;
    step("overrun");
    overrun_error = 1'b0;
    check("overrun stat", stat_overrun_o[0], 1);
    step("overrun_irq");
    check("overrun irq", irq_o[0], 1);
    irq_en = 1'b0;
    step("irq_dis");
    check("irq disabled", irq_o[0], 0);
    clr_status = 1'b1;
    step("irq_clr");
    clr_status = 1'b0;

    // Boundaries: empty pop, push+pop at count 2 across wrap
    pop = 1'b1;
    step("empty_pop");
    pop = 1'b0;
    check("empty pop count", count_o[0], 0);
    send(8'hA1, 1'b0, "bnd");
    send(8'hA2, 1'b0, "bnd");
    data_ready = 1'b1; rx_data = 8'hA3; pop = 1'b1;
    step("push_pop");
    pop = 1'b0;
    check("push_pop count", count_o[0], 2);
    check("push_pop head",  rd_data_o[0], 8'hA2);
    step("push_pop_wait");
    data_ready = 1'b0;
    step("push_pop_idle");
    data_ready = 1'b1; rx_data = 8'hA4; pop = 1'b1;
    step("push_pop2");
    pop = 1'b0;
    check("push_pop2 head", rd_data_o[0], 8'hA3);
    step("push_pop2_wait");
    data_ready = 1'b0;
    step("push_pop2_idle");
    pop = 1'b1;
    step("wrap_drain");
    check("wrap order", rd_data_o[0], 8'hA4);
    step("wrap_drain");
    pop = 1'b0;

    // Reset during the acknowledge cycle
    send(8'h77, 1'b0, "rst_pre");
    data_ready = 1'b1; rx_data = 8'h5A; overrun_error = 1'b1;
    step("rst_ack");
    overrun_error = 1'b0;
    check("rst pre ack", data_read_o[0], 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst_async");
    check("rst data_read",    data_read_o[0],    0);
    check("rst count",        count_o[0],        0);
    check("rst stat_overrun", stat_overrun_o[0], 0);
    check("rst rd_data",      rd_data_o[0],      8'h00);
    step("rst_hold");
    rst = 1'b0;
    step("rst_recap");
    check("rst recapture count", count_o[0],     1);
    check("rst recapture data",  rd_data_o[0],   8'h5A);
    check("rst recapture ack",   data_read_o[0], 1);
    data_ready = 1'b0;
    step("rst_after");
    step("rst_after");

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      data_ready    = ($urandom_range(0, 3) != 0);
      rx_data       = 8'($urandom);
      error_flag    = ($urandom_range(0, 7) == 0);
      overrun_error = ($urandom_range(0, 31) == 0);
      pop           = ($urandom_range(0, 2) == 0);
      clr_status    = ($urandom_range(0, 15) == 0);
      irq_en        = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) irq_thresh = CNT_W'($urandom_range(0, DEPTH));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
